// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle load/store engine between the control FSM and a
// handshaked, word-organised data memory. It accepts one request per start
// strobe, drives a word-aligned access with byte enables and lane-replicated
// store data, waits for mem_ready, then pulses done with extended load data.
//
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned word/halfword accesses
// skip the memory and complete at once with err=1. When it is undefined, err is
// tied low and the offending low address bits are ignored.
module mem_access_unit #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    memwrite,
    input  logic [1:0]    ltype,
    input  logic          lsigned,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;
    typedef enum logic [1:0] {SzWord, SzHalf, SzByte} size_t;

    state_t          state_q, state_d;
    size_t           sz_n;
    size_t           lsz_q;
    logic            lsigned_q;
    logic [1:0]      off_q;
    logic            load_q;
    logic            mem_we_q;
    logic [3:0]      mem_be_q, be_n;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q, wdata_n;
    logic [DW-1:0]   rdata_q, load_ext;
    logic            trap_n;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            err_q;
`endif

    // Decode the incoming request: access size, byte enables, store data lanes.
    always_comb begin
        sz_n    = SzWord;
        be_n    = 4'b1111;
        wdata_n = wdata;
        trap_n  = 1'b0;
        if (memwrite == 2'b00) begin
            unique case (ltype)
                2'b01:   sz_n = SzHalf;
                2'b10:   sz_n = SzByte;
                default: sz_n = SzWord;  // 11 reserved, treated as word
            endcase
        end else begin
            unique case (memwrite)
                2'b10:   sz_n = SzHalf;
                2'b11:   sz_n = SzByte;
                default: sz_n = SzWord;
            endcase
            unique case (sz_n)
                SzHalf: begin
                    be_n    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{wdata[15:0]}};
                end
                SzByte: begin
                    be_n    = 4'b0001 << addr[1:0];
                    wdata_n = {4{wdata[7:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = wdata;
                end
            endcase
        end
`ifdef MEM_MISALIGN_TRAP_EN
        trap_n = ((sz_n == SzWord) && (addr[1:0] != 2'b00)) ||
                 ((sz_n == SzHalf) && addr[0]);
`endif
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        load_ext = mem_rdata;
        unique case (lsz_q)
            SzHalf: begin
                load_ext = off_q[1] ? {{16{lsigned_q & mem_rdata[31]}}, mem_rdata[31:16]}
                                    : {{16{lsigned_q & mem_rdata[15]}}, mem_rdata[15:0]};
            end
            SzByte: begin
                unique case (off_q)
                    2'b00:   load_ext = {{24{lsigned_q & mem_rdata[7]}},  mem_rdata[7:0]};
                    2'b01:   load_ext = {{24{lsigned_q & mem_rdata[15]}}, mem_rdata[15:8]};
                    2'b10:   load_ext = {{24{lsigned_q & mem_rdata[23]}}, mem_rdata[23:16]};
                    default: load_ext = {{24{lsigned_q & mem_rdata[31]}}, mem_rdata[31:24]};
                endcase
            end
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic for the IDLE -> REQ -> RESP handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = trap_n ? StResp : StReq;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and request registers; request fields only load when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lsz_q       <= SzWord;
            lsigned_q   <= 1'b0;
            off_q       <= 2'b00;
            load_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && start) begin
                lsz_q       <= sz_n;
                lsigned_q   <= lsigned;
                off_q       <= addr[1:0];
                load_q      <= (memwrite == 2'b00);
                mem_we_q    <= (memwrite != 2'b00);
                mem_be_q    <= be_n;
                mem_addr_q  <= {addr[AW-1:2], 2'b00};
                mem_wdata_q <= wdata_n;
`ifdef MEM_MISALIGN_TRAP_EN
                err_q       <= trap_n;
`endif
            end
            if ((state_q == StReq) && mem_ready && load_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    assign mem_req   = (state_q == StReq);
    assign busy      = (state_q == StReq);
    assign done      = (state_q == StResp);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign err       = done & err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by random accesses,
// every result compared with a byte-lane reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  memwrite = 2'b00;
    logic [1:0]  ltype = 2'b00;
    logic        lsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, busy, err, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_rdata = '0;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .ltype(ltype),
        .lsigned(lsigned), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .busy(busy), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access width in bytes.
    function automatic int unsigned acc_size(input logic [1:0] mw, input logic [1:0] lt);
        if (mw == 2'b00) return (lt == 2'b01) ? 2 : (lt == 2'b10) ? 1 : 4;
        return (mw == 2'b10) ? 2 : (mw == 2'b11) ? 1 : 4;
    endfunction

    // Byte offset actually used inside the word.
    function automatic int unsigned lane_off(input int unsigned sz, input logic [31:0] a);
        if (sz == 4) return 0;
        if (sz == 2) return a & 2;
        return a & 3;
    endfunction

    function automatic bit misaligned(input int unsigned sz, input logic [31:0] a);
        return (sz == 4 && (a & 3) != 0) || (sz == 2 && (a & 1) != 0);
    endfunction

    function automatic logic [31:0] exp_be(input logic [1:0] mw, input logic [1:0] lt,
                                           input logic [31:0] a);
        int unsigned sz = acc_size(mw, lt);
        if (mw == 2'b00) return 32'hF;
        return ((32'd1 << sz) - 1) << lane_off(sz, a);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] mw, input logic [31:0] wd);
        int unsigned sz = acc_size(mw, 2'b00);
        if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] lt, input logic ls,
                                             input logic [31:0] a, input logic [31:0] rd);
        int unsigned sz = acc_size(2'b00, lt);
        longint unsigned mask = (64'd1 << (8 * sz)) - 1;
        longint unsigned val  = ({32'd0, rd} >> (8 * lane_off(sz, a))) & mask;
        if (ls && sz < 4 && val[8*sz-1]) val = val | (~mask);
        return val[31:0];
    endfunction

    // One complete access: start, waits cycles of mem_ready=0, then ready,
    // then the done cycle and one trailing idle cycle. With poke, stray starts
    // (with a different address) are issued in REQ and in RESP.
    task automatic access(input logic [1:0] mw, input logic [1:0] lt, input logic ls,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input bit poke);
        int unsigned sz = acc_size(mw, lt);
        bit trapped = Trap && misaligned(sz, a);
        @(negedge clk);
        start = 1'b1; memwrite = mw; ltype = lt; lsigned = ls; addr = a; wdata = wd;
        mem_rdata = rd; mem_ready = 1'($urandom_range(1));
        @(negedge clk);
        start = 1'b0;
        if (!trapped) begin
            for (int k = 0; k <= waits; k++) begin
                check("req", mem_req, 1);
                check("busy", busy, 1);
                check("done_in_req", done, 0);
                check("we", mem_we, (mw != 2'b00));
                check("be", mem_be, exp_be(mw, lt, a));
                check("maddr", mem_addr, a & 32'hFFFF_FFFC);
                if (mw != 2'b00) check("mwdata", mem_wdata, exp_wdata(mw, wd));
                if (poke && k == 0) begin
                    start = 1'b1; addr = a ^ 32'h100;
                end
                mem_ready = (k == waits);
                @(negedge clk);
                start = 1'b0; addr = a;
            end
            if (mw == 2'b00) model_rdata = exp_load(lt, ls, a, rd);
        end
        check("done", done, 1);
        check("busy_resp", busy, 0);
        check("req_resp", mem_req, 0);
        check("err", err, trapped);
        check("rdata", rdata, model_rdata);
        mem_ready = 1'($urandom_range(1));
        if (poke) begin
            start = 1'b1; addr = a ^ 32'h200;
        end
        @(negedge clk);
        start = 1'b0; addr = a;
        check("done_after", done, 0);
        check("req_after", mem_req, 0);
        check("busy_after", busy, 0);
        mem_ready = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_rdata", rdata, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_be", mem_be, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwdata", mem_wdata, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        model_rdata = '0;

        // Byte store at 0x6, ready already high.
        access(2'b11, 2'b00, 1'b0, 32'h6, 32'hA5, 32'h0, 0, 1'b0);
        // Signed halfword load at 0x12 with three wait cycles.
        access(2'b00, 2'b01, 1'b1, 32'h12, 32'h0, 32'h8001_7FFF, 3, 1'b0);
        // Byte loads from the top lane, zero- and sign-extended.
        access(2'b00, 2'b10, 1'b0, 32'h3, 32'h0, 32'h9C00_0000, 1, 1'b0);
        access(2'b00, 2'b10, 1'b1, 32'h3, 32'h0, 32'h9C00_0000, 0, 1'b0);
        // A store leaves the previous load result in rdata.
        access(2'b10, 2'b00, 1'b0, 32'h2, 32'h1234_BEEF, 32'h0, 0, 1'b0);
        // Stray starts during REQ and RESP are ignored.
        access(2'b01, 2'b00, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 2, 1'b1);
        // mem_ready while idle has no effect.
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_req", mem_req, 0);
            check("idle_done", done, 0);
        end
        mem_ready = 1'b0;
        // Word load at 0x2: trap or aligned read depending on build.
        access(2'b00, 2'b00, 1'b0, 32'h2, 32'h0, 32'h1357_9BDF, 0, 1'b0);
        // Reserved load type acts as a word load.
        access(2'b00, 2'b11, 1'b1, 32'h8, 32'h0, 32'hF0E0_D0C0, 1, 1'b0);

        // Reset while waiting in REQ.
        @(negedge clk);
        start = 1'b1; memwrite = 2'b00; ltype = 2'b00; addr = 32'h100; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        model_rdata = '0;
        access(2'b00, 2'b10, 1'b1, 32'h101, 32'h0, 32'h0000_8000, 0, 1'b0);

        // Random accesses.
        for (int i = 0; i < 60; i++) begin
            access(2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                   $urandom, $urandom, $urandom, int'($urandom_range(3)),
                   bit'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
